hazard_ctrl: RTL

- Pipeline controller for the 5-stage RISC-V core. Drives stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the operand-forwarding selects for the EX stage.
- Sequences data-memory accesses in MEM through a req/ready handshake. Freezes the front of the pipe while memory is busy.
- Keeps a timeout flag and a stall-cycle counter for debug.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_ctrl_fwd_sel.sv | 26 ++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// ResultSrc encodings, EX operand-forward codes and the memory-wait FSM states.
package hazard_ctrl_pkg;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline hazard information, stall/flush/forward controls and the
// data-memory req/ready handshake.
//   master : the hazard controller (consumes pipeline info and dmem_ready,
//            drives controls, dmem_req and debug status)
//   slave  : the pipeline / memory side
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       Rs1D, Rs2D;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic [4:0]       RdM;
  logic             RegWriteM;
  logic [1:0]       ResultSrcM;
  logic             MemWriteM;
  logic [4:0]       RdW;
  logic             RegWriteW;
  logic             dmem_ready;
  logic             dmem_req;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             dmem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, ResultSrcM, MemWriteM, RdW, RegWriteW, dmem_ready,
    output dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, dmem_timeout, stall_cycles
  );

  modport slave (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, ResultSrcM, MemWriteM, RdW, RegWriteW, dmem_ready,
    input  dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, dmem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forward select for one EX source register.
//   rs_e_i                      : source register in EX
//   rd_m_i / reg_write_m_i      : MEM destination and write enable
//   rd_w_i / reg_write_w_i      : WB destination and write enable
//   fwd_o                       : FWD_MEM, FWD_WB or FWD_RF (MEM wins over WB)
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use stall, branch
// flush, EX operand forwarding and data-memory wait sequencing with a sticky
// timeout flag and a saturating stall-cycle counter.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : hazard_ctrl_if master modport (pipeline info in, controls out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no access outstanding; dmem_req follows memAcc
// MEM_WAIT | access issued but not yet acknowledged; front of pipe frozen
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.master bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic       mem_acc, req, mem_stall, lw_stall;
  logic [1:0] fwd_a, fwd_b;

  assign mem_acc   = bus.MemWriteM | (bus.ResultSrcM == RES_LOAD);
  assign mem_stall = req & ~bus.dmem_ready;
  assign lw_stall  = (bus.ResultSrcE == RES_LOAD) && (bus.RdE != 5'd0) &&
                     ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));

  hazard_ctrl_fwd_sel u_fwd_a (
    .rs_e_i(bus.Rs1E), .rd_m_i(bus.RdM), .reg_write_m_i(bus.RegWriteM),
    .rd_w_i(bus.RdW), .reg_write_w_i(bus.RegWriteW), .fwd_o(fwd_a)
  );

  hazard_ctrl_fwd_sel u_fwd_b (
    .rs_e_i(bus.Rs2E), .rd_m_i(bus.RdM), .reg_write_m_i(bus.RegWriteM),
    .rd_w_i(bus.RdW), .reg_write_w_i(bus.RegWriteW), .fwd_o(fwd_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        req = mem_acc;
        if (mem_acc && !bus.dmem_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        req = 1'b1;
        if (bus.dmem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait timer counts down from MAX_WAIT while in MEM_WAIT; hitting terminal
  // count latches the timeout but the FSM keeps waiting for ready.
  always_comb begin
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (state_q == IDLE) begin
      wait_d = WAIT_W'(MAX_WAIT);
    end else if (wait_q != '0) begin
      wait_d = wait_q - 1'b1;
      if (wait_q == WAIT_W'(1)) timeout_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // A memory stall masks branch/load-use flushes so the held instructions
  // survive; a branch still in EX is flushed on the release cycle.
  always_comb begin
    bus.dmem_req  = req;
    bus.StallF    = lw_stall | mem_stall;
    bus.StallD    = lw_stall | mem_stall;
    bus.StallE    = mem_stall;
    bus.StallM    = mem_stall;
    bus.FlushD    = bus.PCSrcE & ~mem_stall;
    bus.FlushE    = (lw_stall | bus.PCSrcE) & ~mem_stall;
    bus.FlushW    = mem_stall;
    bus.ForwardAE = fwd_a;
    bus.ForwardBE = fwd_b;
    if (reset) begin
      bus.dmem_req  = 1'b0;
      bus.StallF    = 1'b0;
      bus.StallD    = 1'b0;
      bus.StallE    = 1'b0;
      bus.StallM    = 1'b0;
      bus.FlushD    = 1'b1;
      bus.FlushE    = 1'b1;
      bus.FlushW    = 1'b1;
      bus.ForwardAE = FWD_RF;
      bus.ForwardBE = FWD_RF;
    end
  end

  assign bus.dmem_timeout = timeout_q;
  assign bus.stall_cycles = stall_cnt_q;

endmodule
